// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and address check for the data-memory responder
//
// Contents:
//   state_t     responder FSM states (ST_IDLE / ST_WAIT / ST_RESP)
//   WORD_BYTES  bytes per stored word
//   addr_err()  1 when an access is misaligned or falls past the last word
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // The address is passed zero-extended to 64 bits so one function serves any ADDR_W.
    function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with synchronous write and registered read
//
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-low reset; clears every word and the read register
//   we      write strobe
//   index   word index
//   wdata   write data
//   be      per-byte write strobes (only with DMEM_BYTE_ENABLE_EN defined)
//   rdata   registered read of mem[index], taken before any same-edge write
import dmem_pkg::*;

module dmem_array #(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we,
    input  logic [IDX_W-1:0]          index,
    input  logic [WORD_BYTES*8-1:0]   wdata,
`ifdef DMEM_BYTE_ENABLE_EN
    input  logic [WORD_BYTES-1:0]     be,
`endif
    output logic [WORD_BYTES*8-1:0]   rdata
);

    logic [WORD_BYTES*8-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
`ifdef DMEM_BYTE_ENABLE_EN
                for (int k = 0; k < WORD_BYTES; k++) begin
                    if (be[k]) begin
                        mem[index][8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
`else
                mem[index] <= wdata;
`endif
            end
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle load/store responder with programmable wait states
//
// Optional feature macro: DMEM_BYTE_ENABLE_EN (adds req_be_i per-byte store strobes)
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     request handshake
//   req_write_i, req_addr_i,
//   req_wdata_i (, req_be_i)      request payload
//   resp_valid_o / resp_ready_i   response handshake; payload held until accepted
//   resp_rdata_o, resp_err_o      load data (0 for stores/errors), access error
import dmem_pkg::*;

module dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
`ifdef DMEM_BYTE_ENABLE_EN
    input  logic [3:0]        req_be_i,
`endif
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    input  logic              resp_ready_i
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 2);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   arr_rdata;

    // Access operands: in IDLE the zero-wait path commits straight from the request
    // inputs; otherwise the latched copy is used.
    logic                acc_write;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_err;
    logic                commit;
    logic                arr_we;

    assign acc_write = (state_q == ST_IDLE) ? req_write_i : write_q;
    assign acc_addr  = (state_q == ST_IDLE) ? req_addr_i  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? req_wdata_i : wdata_q;
    assign acc_err   = addr_err(64'(acc_addr), DEPTH_WORDS);

`ifdef DMEM_BYTE_ENABLE_EN
    logic [3:0] be_q;
    logic [3:0] acc_be;
    assign acc_be = (state_q == ST_IDLE) ? req_be_i : be_q;
`endif

    assign commit = ((state_q == ST_IDLE) && req_valid_i && (WAIT_CYCLES == 0)) ||
                    ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));
    assign arr_we = commit && acc_write && !acc_err;

    // The array re-reads mem[index] every edge; index stays on addr_q through RESP and
    // no write happens there, so the captured load data holds stable.
    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (arr_we),
        .index (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
`ifdef DMEM_BYTE_ENABLE_EN
        .be    (acc_be),
`endif
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid_i) state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            ST_RESP: if (resp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == ST_IDLE);
        resp_valid_o = (state_q == ST_RESP);
        resp_err_o   = (state_q == ST_RESP) && err_q;
        resp_rdata_o = ((state_q == ST_RESP) && !write_q && !err_q) ? arr_rdata : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_BYTE_ENABLE_EN
            be_q    <= '0;
`endif
        end else begin
            if ((state_q == ST_IDLE) && req_valid_i) begin
                cnt_q   <= CNT_W'(WAIT_CYCLES);
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
`ifdef DMEM_BYTE_ENABLE_EN
                be_q    <= req_be_i;
`endif
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (commit) begin
                err_q <= acc_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench: directed table, hand sequences, random vs model
module tb_dmem_responder;

    localparam int WAIT  = 2;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_err, resp_ready;
    logic [31:0] resp_rdata;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
`ifdef DMEM_BYTE_ENABLE_EN
        .req_be_i     (req_be),
`endif
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .resp_ready_i (resp_ready)
    );

    int n_pass = 0;
    int n_chk  = 0;

    logic [31:0] ref_mem [DEPTH];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        e;
        logic [31:0] rd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic e, input logic [31:0] rd);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.be = be; v.e = e; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    endtask

    // Reference behaviour: error on misalignment or word index past the end, otherwise
    // a store updates the word (enabled bytes only with byte enables) and a load returns it.
    task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, output logic e, output logic [31:0] rd);
        int idx;
        e  = (a % 4 != 0) || ((a / 4) >= DEPTH);
        rd = 32'h0;
        if (!e) begin
            idx = int'(a / 4);
            if (w) begin
`ifdef DMEM_BYTE_ENABLE_EN
                for (int k = 0; k < 4; k++)
                    if (be[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
`else
                ref_mem[idx] = d;
`endif
            end else begin
                rd = ref_mem[idx];
            end
        end
    endtask

    // Drives one transaction from IDLE and returns the response. Called and returning at
    // a negedge. Junk request traffic is offered while the responder is busy.
    task automatic bus_txn(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be, input int stall,
                           output logic got_err, output logic [31:0] got_rd);
        int lat;
        chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'($urandom); req_write = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(WAIT + 1));
        chk({tag, " ready_busy"}, 32'(req_ready), 32'd0);
        got_err = resp_err;
        got_rd  = resp_rdata;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, " hold_rdata"}, resp_rdata, got_rd);
            chk({tag, " hold_err"}, 32'(resp_err), 32'(got_err));
            chk({tag, " hold_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk({tag, " idle_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; resp_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e, me;
        logic [31:0] rd, mrd;
        logic        w;
        logic [31:0] a, d;
        logic [3:0]  be;
        int          sel;

        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = 4'hF; resp_ready = 1'b0; rst_n = 1'b0;
        model_clear();

        vt.push_back(mk(1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 32'h0));
        vt.push_back(mk(1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hDEADBEEF));
        vt.push_back(mk(1'b0, 32'h13,       32'h0,        4'hF, 1'b1, 32'h0));
        vt.push_back(mk(1'b1, 32'h200,      32'hCAFEF00D, 4'hF, 1'b1, 32'h0));
        vt.push_back(mk(1'b0, 32'h0,        32'h0,        4'hF, 1'b0, 32'h0));
        vt.push_back(mk(1'b1, 32'h1FC,      32'h55AA55AA, 4'hF, 1'b0, 32'h0));
        vt.push_back(mk(1'b0, 32'h1FC,      32'h0,        4'hF, 1'b0, 32'h55AA55AA));
        vt.push_back(mk(1'b1, 32'h2,        32'h11111111, 4'hF, 1'b1, 32'h0));
        vt.push_back(mk(1'b0, 32'h0,        32'h0,        4'hF, 1'b0, 32'h0));
        vt.push_back(mk(1'b0, 32'h80000000, 32'h0,        4'hF, 1'b1, 32'h0));
        vt.push_back(mk(1'b1, 32'h10,       32'h01020304, 4'hF, 1'b0, 32'h0));
        vt.push_back(mk(1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'h01020304));
`ifdef DMEM_BYTE_ENABLE_EN
        vt.push_back(mk(1'b1, 32'h8,        32'hFFFFFFFF, 4'hF, 1'b0, 32'h0));
        vt.push_back(mk(1'b1, 32'h8,        32'h000000AA, 4'h1, 1'b0, 32'h0));
        vt.push_back(mk(1'b0, 32'h8,        32'h0,        4'h0, 1'b0, 32'hFFFFFFAA));
        vt.push_back(mk(1'b1, 32'h8,        32'h12345678, 4'h0, 1'b0, 32'h0));
        vt.push_back(mk(1'b0, 32'h8,        32'h0,        4'h3, 1'b0, 32'hFFFFFFAA));
        vt.push_back(mk(1'b1, 32'h8,        32'hA5B6C7D8, 4'hC, 1'b0, 32'h0));
        vt.push_back(mk(1'b0, 32'h8,        32'h0,        4'hF, 1'b0, 32'hA5B6FFAA));
`endif

        // Reset state, during and after reset with no traffic.
        @(negedge clk);
        chk("rst ready", 32'(req_ready), 32'd1);
        chk("rst valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle ready", 32'(req_ready), 32'd1);
        chk("idle valid", 32'(resp_valid), 32'd0);
        chk("idle rdata", resp_rdata, 32'h0);
        chk("idle err", 32'(resp_err), 32'd0);

        // Directed table.
        for (int i = 0; i < vt.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            model_txn(vt[i].w, vt[i].a, vt[i].d, vt[i].be, me, mrd);
            bus_txn(tag, vt[i].w, vt[i].a, vt[i].d, vt[i].be, 0, e, rd);
            chk({tag, " err"}, 32'(e), 32'(vt[i].e));
            chk({tag, " rdata"}, rd, vt[i].rd);
        end

        // Backpressure: load held for 5 cycles.
        model_txn(1'b0, 32'h10, 32'h0, 4'hF, me, mrd);
        bus_txn("bp", 1'b0, 32'h10, 32'h0, 4'hF, 5, e, rd);
        chk("bp err", 32'(e), 32'd0);
        chk("bp rdata", rd, 32'h01020304);

        // Reset during WAIT discards the pending store.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("midrst ready", 32'(req_ready), 32'd1);
        chk("midrst valid", 32'(resp_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst ready", 32'(req_ready), 32'd1);
        bus_txn("postrst ld20", 1'b0, 32'h20, 32'h0, 4'hF, 0, e, rd);
        chk("postrst ld20 rdata", rd, 32'h0);
        chk("postrst ld20 err", 32'(e), 32'd0);
        bus_txn("postrst ld10", 1'b0, 32'h10, 32'h0, 4'hF, 1, e, rd);
        chk("postrst ld10 rdata", rd, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            string tag;
            tag = $sformatf("rnd%0d", i);
            sel = int'($urandom_range(0, 9));
            w   = 1'($urandom);
            d   = $urandom;
            be  = 4'($urandom);
            if (sel < 7)       a = {26'h0, 4'($urandom), 2'b00};
            else if (sel == 7) a = {26'h0, 4'($urandom), 2'($urandom_range(1, 3))};
            else if (sel == 8) a = {20'h0, 10'($urandom_range(128, 1023)), 2'b00};
            else               a = $urandom;
            model_txn(w, a, d, be, me, mrd);
            bus_txn(tag, w, a, d, be, int'($urandom_range(0, 2)), e, rd);
            chk({tag, " err"}, 32'(e), 32'(me));
            chk({tag, " rdata"}, rd, mrd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
